// File: rtl/adc_frame_streamer.sv
// ---------------------------------------------------------------------------
// adc_frame_streamer
//
// Purpose:
//   Packs one snapshot of eight ADC channel packets, plus a 16-bit frame
//   sequence number, into a byte stream on an AXI4-Stream master port.
//   Frame layout, MSB byte first throughout:
//     seq[15:8], seq[7:0], ch0, ch1, ... ch7
//   A holdoff window after each accepted frame filters out the repeated
//   data_ready strobes that the deserializer produces within one ADC frame.
//   A strobe that arrives outside holdoff while a frame is still being sent
//   is counted as a dropped frame.
//
// Parameters:
//   BITS_PER_PACKET  width of each channel packet (16, 24, 32 or 40)
//   HOLDOFF_CYCLES   clk cycles after an accepted frame during which
//                    data_ready is ignored (0..65535)
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   ch0..ch7_packet  latched channel packets from the TDM deserializer
//   data_ready       one-clk strobe, new packets available
//   m_axis_tdata     stream byte
//   m_axis_tvalid    stream byte valid
//   m_axis_tready    downstream accept
//   m_axis_tlast     final byte of a frame
//   frame_seq        sequence number of the frame in flight or last sent
//   drop_count       frames lost because the block was busy (saturating)
//   busy             high while a frame is being sent
// ---------------------------------------------------------------------------
module adc_frame_streamer #(
  parameter int unsigned BITS_PER_PACKET = 24,
  parameter int unsigned HOLDOFF_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BITS_PER_PACKET-1:0] ch0_packet,
  input  logic [BITS_PER_PACKET-1:0] ch1_packet,
  input  logic [BITS_PER_PACKET-1:0] ch2_packet,
  input  logic [BITS_PER_PACKET-1:0] ch3_packet,
  input  logic [BITS_PER_PACKET-1:0] ch4_packet,
  input  logic [BITS_PER_PACKET-1:0] ch5_packet,
  input  logic [BITS_PER_PACKET-1:0] ch6_packet,
  input  logic [BITS_PER_PACKET-1:0] ch7_packet,
  input  logic                       data_ready,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [15:0]                frame_seq,
  output logic [15:0]                drop_count,
  output logic                       busy
);

  localparam int unsigned BYTES_PER_PKT = BITS_PER_PACKET / 8;
  localparam int unsigned FRAME_BYTES   = 2 + 8 * BYTES_PER_PKT;
  localparam int unsigned FRAME_W       = 8 * FRAME_BYTES;
  localparam logic [5:0]  LAST_IDX      = 6'(FRAME_BYTES - 1);
  localparam logic [15:0] HOLDOFF_LOAD  = 16'(HOLDOFF_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [5:0]         idx_q;
  logic [15:0]        holdoff_q;
  logic [15:0]        holdoff_d;
  logic [15:0]        nextSeq_q;
  logic [15:0]        seq_q;
  logic [15:0]        drop_q;
  logic [15:0]        drop_d;
  logic               tvalid_q;
  logic               tlast_q;

  logic               handshake;
  logic               lastHandshake;
  logic               holdoffClear;
  logic               accept;
  logic               drop;
  logic [FRAME_W-1:0] newFrame;

  // Acceptance is allowed either from IDLE or on the exact cycle the current
  // frame's final byte is taken, which gives gap-free back-to-back frames.
  // Any other strobe outside holdoff while sending is a lost frame.
  always_comb begin
    handshake     = tvalid_q & m_axis_tready;
    lastHandshake = (state_q == SEND) & handshake & (idx_q == LAST_IDX);
    holdoffClear  = (holdoff_q == 16'd0);
    accept        = data_ready & holdoffClear &
                    ((state_q == IDLE) | lastHandshake);
    drop          = data_ready & holdoffClear &
                    (state_q == SEND) & ~lastHandshake;
    newFrame      = {nextSeq_q,
                     ch0_packet, ch1_packet, ch2_packet, ch3_packet,
                     ch4_packet, ch5_packet, ch6_packet, ch7_packet};
  end

  // Holdoff runs on its own regardless of the FSM state; the drop counter
  // sticks at its maximum rather than wrapping back to a misleading small value.
  always_comb begin
    holdoff_d = holdoff_q;
    if (accept) begin
      holdoff_d = HOLDOFF_LOAD;
    end else if (!holdoffClear) begin
      holdoff_d = holdoff_q - 16'd1;
    end

    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Frame FSM. The frame buffer is a shift register whose top byte is the
  // stream byte; shifting in zeros means tdata reads 0 once a frame has
  // fully drained and the block is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      holdoff_q <= '0;
      nextSeq_q <= '0;
      seq_q     <= '0;
      drop_q    <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      holdoff_q <= holdoff_d;
      drop_q    <= drop_d;

      if (accept) begin
        frame_q   <= newFrame;
        seq_q     <= nextSeq_q;
        nextSeq_q <= nextSeq_q + 16'd1;
        idx_q     <= '0;
        state_q   <= SEND;
        tvalid_q  <= 1'b1;
        tlast_q   <= 1'b0;
      end else if (lastHandshake) begin
        frame_q  <= frame_q << 8;
        idx_q    <= '0;
        state_q  <= IDLE;
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end else if ((state_q == SEND) && handshake) begin
        frame_q <= frame_q << 8;
        idx_q   <= idx_q + 6'd1;
        tlast_q <= ((idx_q + 6'd1) == LAST_IDX);
      end
    end
  end

  assign m_axis_tdata  = frame_q[FRAME_W-1 -: 8];
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_seq     = seq_q;
  assign drop_count    = drop_q;
  assign busy          = (state_q == SEND);

endmodule
